mac_array_sequencer: RTL and testbench

- Instruction-driven sequencer for the MAC array control datapath. It accepts one 32-bit instruction at a time: COMPUTE (87) or LOADIFMAPS (88).
- For COMPUTE it fetches K*K weights from weight BRAM into the preload shift registers, then commits them to the MACs, then streams ifmaps from the FIFO.
- For LOADIFMAPS it streams ifmaps only, reusing the weights already committed.
- It drives the load_weight_preload, load_MAC_weight and load_ifmaps strobes of the MAC array control block.

---
 rtl/mac_array_sequencer_if.sv | 50 +++++
 rtl/mac_array_sequencer.sv | 153 +++++++++++++++
 tb/tb_mac_array_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_sequencer_if.sv
// -----------------------------------------------------------------------------
// mac_array_sequencer_if
// Bundles the instruction handshake, weight BRAM read port, MAC array strobes,
// ifmap FIFO pop and status flags of the MAC array sequencer.
//
// Handshake: an instruction (inst plus all cfg_* fields) transfers on a rising
// edge where inst_valid & inst_ready are both high. inst_ready is driven only
// by the sequencer's own state and never depends on inst_valid. The upstream
// side holds inst/cfg_* stable while inst_valid is high. cfg_* is not looked
// at in any other cycle.
//
// Modports:
//   master : upstream / instruction issuer and FIFO flag source
//   slave  : the sequencer
// -----------------------------------------------------------------------------
interface mac_array_sequencer_if #(
   parameter int BRAM_ADDRESS_WIDTH = 12,
   parameter int CNT_WIDTH          = 16
);
   logic [31:0]                   inst;
   logic                          inst_valid;
   logic                          inst_ready;
   logic [4:0]                    cfg_kernel_size;
   logic [BRAM_ADDRESS_WIDTH-1:0] cfg_weight_base;
   logic [CNT_WIDTH-1:0]          cfg_ifmaps_count;
   logic                          bram_en;
   logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr;
   logic                          load_weight_preload;
   logic                          load_MAC_weight;
   logic                          load_ifmaps;
   logic                          ifmaps_fifo_empty;
   logic                          ifmaps_rd_en;
   logic                          busy;
   logic                          done;
   logic                          err;

   modport master (
      output inst, inst_valid, cfg_kernel_size, cfg_weight_base,
             cfg_ifmaps_count, ifmaps_fifo_empty,
      input  inst_ready, bram_en, bram_addr, load_weight_preload,
             load_MAC_weight, load_ifmaps, ifmaps_rd_en, busy, done, err
   );

   modport slave (
      input  inst, inst_valid, cfg_kernel_size, cfg_weight_base,
             cfg_ifmaps_count, ifmaps_fifo_empty,
      output inst_ready, bram_en, bram_addr, load_weight_preload,
             load_MAC_weight, load_ifmaps, ifmaps_rd_en, busy, done, err
   );
endinterface

// File: rtl/mac_array_sequencer.sv
// -----------------------------------------------------------------------------
// mac_array_sequencer
// Instruction-driven sequencer for the MAC array control datapath.
//   COMPUTE    (87): fetch K*K weights from BRAM into the preload shift chain,
//                    commit them to the MACs, then stream ifmap beats.
//   LOADIFMAPS (88): stream ifmap beats only, reusing committed weights.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          mac_array_sequencer_if.slave (instruction, BRAM, strobes, FIFO)
//   o_dbg_state  current FSM state encoding (IDLE=0 .. DONE=5)
// -----------------------------------------------------------------------------
module mac_array_sequencer #(
   parameter int BRAM_ADDRESS_WIDTH = 12,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   mac_array_sequencer_if.slave        bus,
   output logic [2:0]                  o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_W_FETCH  = 3'd1,
      ST_W_DRAIN  = 3'd2,
      ST_W_COMMIT = 3'd3,
      ST_STREAM   = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam logic [31:0] OP_COMPUTE    = 32'd87;
   localparam logic [31:0] OP_LOADIFMAPS = 32'd88;

   state_t                        r_state;
   state_t                        w_next_state;
   logic [4:0]                    r_k;
   logic [BRAM_ADDRESS_WIDTH-1:0] r_base;
   logic [CNT_WIDTH-1:0]          r_remaining;
   logic [4:0]                    r_fetch_cnt;
   logic                          r_preload;
   logic                          r_err;

   logic [9:0] w_kk;
   logic       w_accept;
   logic       w_op_compute;
   logic       w_op_load;
   logic       w_k_legal;
   logic       w_reject;
   logic       w_last_fetch;
   logic       w_bram_en;
   logic       w_pop;
   logic       w_commit;

   assign w_kk         = 10'(r_k) * 10'(r_k);
   assign w_last_fetch = ({5'd0, r_fetch_cnt} == (w_kk - 10'd1));

   assign w_accept     = bus.inst_valid & (r_state == ST_IDLE);
   assign w_op_compute = (bus.inst == OP_COMPUTE);
   assign w_op_load    = (bus.inst == OP_LOADIFMAPS);
   assign w_k_legal    = (bus.cfg_kernel_size != 5'd0) && (bus.cfg_kernel_size <= 5'd5);
   // LOADIFMAPS never looks at K, so only COMPUTE is gated on a legal K.
   assign w_reject     = w_accept & ~(w_op_load | (w_op_compute & w_k_legal));

   always_comb begin
      w_next_state = r_state;
      w_bram_en    = 1'b0;
      w_pop        = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !w_reject) begin
               if (w_op_compute)
                  w_next_state = ST_W_FETCH;
               else if (bus.cfg_ifmaps_count != '0)
                  w_next_state = ST_STREAM;
               else
                  w_next_state = ST_DONE;
            end
         end
         ST_W_FETCH: begin
            w_bram_en = 1'b1;
            if (w_last_fetch)
               w_next_state = ST_W_DRAIN;
         end
         // Covers the last preload shift of the word fetched in the final
         // W_FETCH cycle (BRAM read latency of one).
         ST_W_DRAIN: begin
            w_next_state = ST_W_COMMIT;
         end
         ST_W_COMMIT: begin
            w_commit = 1'b1;
            if (r_remaining != '0)
               w_next_state = ST_STREAM;
            else
               w_next_state = ST_DONE;
         end
         ST_STREAM: begin
            w_pop = ~bus.ifmaps_fifo_empty & (r_remaining != '0);
            if (w_pop && (r_remaining == CNT_WIDTH'(1)))
               w_next_state = ST_DONE;
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_k         <= '0;
         r_base      <= '0;
         r_remaining <= '0;
         r_fetch_cnt <= '0;
         r_preload   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         // Preload shift follows the BRAM enable by its one-cycle read latency.
         r_preload <= w_bram_en;
         r_err     <= w_reject;
         if (w_accept) begin
            r_k         <= bus.cfg_kernel_size;
            r_base      <= bus.cfg_weight_base;
            r_remaining <= bus.cfg_ifmaps_count;
            r_fetch_cnt <= '0;
         end else begin
            if (w_bram_en)
               r_fetch_cnt <= r_fetch_cnt + 5'd1;
            if (w_pop)
               r_remaining <= r_remaining - CNT_WIDTH'(1);
         end
      end
   end

   assign bus.inst_ready          = (r_state == ST_IDLE);
   assign bus.busy                = (r_state != ST_IDLE);
   assign bus.done                = (r_state == ST_DONE);
   assign bus.err                 = r_err;
   assign bus.bram_en             = w_bram_en;
   assign bus.bram_addr           = r_base + BRAM_ADDRESS_WIDTH'(r_fetch_cnt);
   assign bus.load_weight_preload = r_preload;
   assign bus.load_MAC_weight     = w_commit;
   assign bus.ifmaps_rd_en        = w_pop;
   assign bus.load_ifmaps         = w_pop;
   assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_mac_array_sequencer.sv
module tb_mac_array_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_array_sequencer_if #(.BRAM_ADDRESS_WIDTH(12), .CNT_WIDTH(16)) bus ();

  mac_array_sequencer #(.BRAM_ADDRESS_WIDTH(12), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- behavioural model state ----------------
  // Cycle-offset view of one instruction: offset n counts cycles after the
  // acceptance edge; weights occupy n=1..K*K, drain K*K+1, commit K*K+2,
  // streaming from stream_start until all beats are popped, then one done cycle.
  bit mon_en = 1'b0;
  bit m_busy = 1'b0;
  bit m_in_done = 1'b0;
  bit m_err_pend = 1'b0;
  int m_n, m_kk, m_base, m_left, m_stream_start;

  // observed activity counters (actual values, compared against literals)
  int n_bram, n_pre, n_commit, n_pop, n_done, n_err, n_busy, done_cyc;
  logic [11:0] addr_q[$];
  logic [11:0] exp_q[$];

  bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : mon
    logic e_ready, e_busy, e_bram, e_pre, e_commit, e_pop, e_done, e_err;
    int   e_addr, k, nstrobe;
    if (mon_en) begin
      e_ready = 0; e_busy = 0; e_bram = 0; e_pre = 0;
      e_commit = 0; e_pop = 0; e_done = 0; e_err = 0; e_addr = 0;
      if (!m_busy) begin
        e_ready = 1;
        e_err   = m_err_pend;
      end else begin
        e_busy = 1;
        if (m_in_done) e_done = 1;
        else if (m_n < m_stream_start) begin
          if (m_n <= m_kk) begin
            e_bram = 1;
            e_addr = (m_base + m_n - 1) % 4096;
          end
          if (m_n >= 2 && m_n <= m_kk + 1) e_pre = 1;
          if (m_n == m_kk + 2) e_commit = 1;
        end else begin
          e_pop = !bus.ifmaps_fifo_empty && (m_left > 0);
        end
      end

      check("inst_ready", bus.inst_ready, e_ready);
      check("busy", bus.busy, e_busy);
      check("bram_en", bus.bram_en, e_bram);
      if (e_bram) check("bram_addr", bus.bram_addr, e_addr);
      check("load_weight_preload", bus.load_weight_preload, e_pre);
      check("load_MAC_weight", bus.load_MAC_weight, e_commit);
      check("ifmaps_rd_en", bus.ifmaps_rd_en, e_pop);
      check("load_ifmaps", bus.load_ifmaps, e_pop);
      check("done", bus.done, e_done);
      check("err", bus.err, e_err);
      nstrobe = int'(bus.load_weight_preload) + int'(bus.load_MAC_weight) + int'(bus.load_ifmaps);
      check("strobe_exclusive", (nstrobe > 1), 0);

      if (bus.bram_en === 1'b1) begin n_bram++; addr_q.push_back(bus.bram_addr); end
      if (bus.load_weight_preload === 1'b1) n_pre++;
      if (bus.load_MAC_weight === 1'b1) n_commit++;
      if (bus.ifmaps_rd_en === 1'b1) n_pop++;
      if (bus.done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (bus.err === 1'b1) n_err++;
      if (bus.busy === 1'b1) n_busy++;

      // advance the model to the next cycle using the inputs the DUT will sample
      if (rst) begin
        m_busy = 0; m_in_done = 0; m_err_pend = 0;
      end else if (!m_busy) begin
        m_err_pend = 0;
        if (bus.inst_valid) begin
          k = int'(bus.cfg_kernel_size);
          if (bus.inst == 32'd87 && k >= 1 && k <= 5) begin
            m_busy = 1; m_in_done = 0; m_n = 1; m_kk = k * k;
            m_base = int'(bus.cfg_weight_base);
            m_left = int'(bus.cfg_ifmaps_count);
            m_stream_start = m_kk + 3;
          end else if (bus.inst == 32'd88) begin
            m_busy = 1; m_n = 1; m_kk = 0;
            m_left = int'(bus.cfg_ifmaps_count);
            m_stream_start = 1;
            m_in_done = (m_left == 0);
          end else begin
            m_err_pend = 1;
          end
        end
      end else if (m_in_done) begin
        m_busy = 0; m_in_done = 0;
      end else begin
        if (m_n >= m_stream_start) begin
          if (e_pop) begin
            m_left--;
            if (m_left == 0) m_in_done = 1;
          end
        end else if (m_n == m_stream_start - 1 && m_left == 0) begin
          m_in_done = 1;
        end
        m_n++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    n_bram = 0; n_pre = 0; n_commit = 0; n_pop = 0;
    n_done = 0; n_err = 0; n_busy = 0; done_cyc = -1;
    addr_q.delete();
    exp_q.delete();
  endtask

  task automatic issue(input logic [31:0] op, input logic [4:0] k,
                       input logic [11:0] base, input logic [15:0] cnt);
    bus.inst             = op;
    bus.cfg_kernel_size  = k;
    bus.cfg_weight_base  = base;
    bus.cfg_ifmaps_count = cnt;
    bus.inst_valid       = 1'b1;
    acc_cyc              = cyc;
    @(posedge clk); #1;
    bus.inst_valid       = 1'b0;
    // scramble the fields afterwards; they must be ignored from now on
    bus.inst             = 32'($urandom_range(0, 200));
    bus.cfg_kernel_size  = 5'($urandom_range(0, 31));
    bus.cfg_weight_base  = 12'($urandom_range(0, 4095));
    bus.cfg_ifmaps_count = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
    end
    check({name, "_timeout"}, ok, 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.inst = '0; bus.inst_valid = 1'b0; bus.cfg_kernel_size = '0;
    bus.cfg_weight_base = '0; bus.cfg_ifmaps_count = '0;
    bus.ifmaps_fifo_empty = 1'b0;
    rst = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    check("reset_inst_ready", bus.inst_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_bram_en", bus.bram_en, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_preload", bus.load_weight_preload, 0);

    // COMPUTE K=3 base=0x010 count=4
    clear_counts();
    issue(32'd87, 5'd3, 12'h010, 16'd4);
    wait_idle(100, "k3");
    check("k3_fetches", n_bram, 9);
    check("k3_preloads", n_pre, 9);
    check("k3_commits", n_commit, 1);
    check("k3_pops", n_pop, 4);
    check("k3_dones", n_done, 1);
    check("k3_latency", done_cyc - acc_cyc, 16);
    check("k3_first_addr", addr_q[0], 12'h010);
    check("k3_last_addr", addr_q[8], 12'h018);

    // COMPUTE K=1 base=0xFFF count=2
    clear_counts();
    issue(32'd87, 5'd1, 12'hFFF, 16'd2);
    wait_idle(100, "k1");
    check("k1_fetches", n_bram, 1);
    check("k1_addr", addr_q[0], 12'hFFF);
    check("k1_preloads", n_pre, 1);
    check("k1_commits", n_commit, 1);
    check("k1_pops", n_pop, 2);
    check("k1_latency", done_cyc - acc_cyc, 6);

    // COMPUTE K=5 base=0xFFE count=3, address wraps
    clear_counts();
    issue(32'd87, 5'd5, 12'hFFE, 16'd3);
    wait_idle(100, "k5");
    check("k5_fetches", n_bram, 25);
    check("k5_preloads", n_pre, 25);
    check("k5_latency", done_cyc - acc_cyc, 31);
    check("k5_addr2_wrap", addr_q[2], 12'h000);
    check("k5_addr24", addr_q[24], 12'h016);
    for (int i = 0; i < 25; i++) exp_q.push_back(12'(12'hFFE + i));
    for (int i = 0; i < 25; i++) check("k5_addr_seq", addr_q[i], exp_q.pop_front());

    // COMPUTE K=2 count=0: commit then straight to done
    clear_counts();
    issue(32'd87, 5'd2, 12'h123, 16'd0);
    wait_idle(100, "k2c0");
    check("k2c0_commits", n_commit, 1);
    check("k2c0_pops", n_pop, 0);
    check("k2c0_latency", done_cyc - acc_cyc, 7);

    // LOADIFMAPS count=3, K=0 is not checked, FIFO empty 1,0,1,1,0,0
    clear_counts();
    issue(32'd88, 5'd0, 12'h000, 16'd3);
    for (int i = 0; i < 6; i++) begin
      bus.ifmaps_fifo_empty = pat[i];
      @(posedge clk); #1;
    end
    bus.ifmaps_fifo_empty = 1'b0;
    wait_idle(50, "ld3");
    check("ld3_pops", n_pop, 3);
    check("ld3_fetches", n_bram, 0);
    check("ld3_preloads", n_pre, 0);
    check("ld3_commits", n_commit, 0);
    check("ld3_errs", n_err, 0);
    check("ld3_latency", done_cyc - acc_cyc, 7);

    // rejects: unknown opcode, K=6, K=0
    clear_counts();
    issue(32'd99, 5'd3, 12'h000, 16'd4);
    step(1);
    issue(32'd87, 5'd6, 12'h000, 16'd4);
    step(1);
    issue(32'd87, 5'd0, 12'h000, 16'd4);
    step(3);
    check("rej_errs", n_err, 3);
    check("rej_fetches", n_bram, 0);
    check("rej_busy_cycles", n_busy, 0);
    check("rej_dones", n_done, 0);

    // reset during cycle 5 of W_FETCH with K=4
    clear_counts();
    issue(32'd87, 5'd4, 12'h100, 16'd2);
    step(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_bram_en", bus.bram_en, 0);
    check("rstmid_preload", bus.load_weight_preload, 0);
    check("rstmid_commit", bus.load_MAC_weight, 0);
    check("rstmid_inst_ready", bus.inst_ready, 1);
    check("rstmid_busy", bus.busy, 0);
    step(5);
    check("rstmid_fetches", n_bram, 5);
    check("rstmid_dones", n_done, 0);

    // LOADIFMAPS count=0 after the aborted COMPUTE
    clear_counts();
    issue(32'd88, 5'd0, 12'h000, 16'd0);
    wait_idle(20, "ld0");
    check("ld0_dones", n_done, 1);
    check("ld0_latency", done_cyc - acc_cyc, 1);
    check("ld0_pops", n_pop, 0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

endmodule
